decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 34 +++
 rtl/decode_logic.sv | 56 +++++
 rtl/decode_stage.sv | 59 +++++
 tb/tb_decode_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, ctrl bit positions, ctrl patterns and length constants for decode_stage
package decode_pkg;
    localparam logic [4:0] OP_MOV_HI   = 5'b10111;
    localparam logic [7:0] OP_ADD_EAX  = 8'h05;
    localparam logic [7:0] OP_ADD_RM   = 8'h01;
    localparam logic [7:0] OP_ADD_IMM8 = 8'h83;
    localparam logic [7:0] OP_JMP      = 8'hE9;
    localparam logic [7:0] OP_HLT      = 8'hF4;

    localparam int CTRL_SRC2MUX = 6;
    localparam int CTRL_OP      = 5;
    localparam int CTRL_READ1   = 4;
    localparam int CTRL_READ2   = 3;
    localparam int CTRL_WE      = 2;
    localparam int CTRL_JMP     = 1;
    localparam int CTRL_HALT    = 0;

    localparam logic [6:0] CTRL_NOP     = 7'b0000000;
    localparam logic [6:0] CTRL_MOV_IMM = 7'b1000100;
    localparam logic [6:0] CTRL_ADD_IMM = 7'b1110100;
    localparam logic [6:0] CTRL_ADD_REG = 7'b0111100;
    localparam logic [6:0] CTRL_JMPREL  = 7'b0000010;
    localparam logic [6:0] CTRL_HALTED  = 7'b0000001;

    localparam logic [7:0] LEN_1 = 8'd1;
    localparam logic [7:0] LEN_2 = 8'd2;
    localparam logic [7:0] LEN_3 = 8'd3;
    localparam logic [7:0] LEN_5 = 8'd5;

    // bytes 2..5 of the instruction form a little-endian 32-bit value
    function automatic logic [31:0] imm32(input logic [39:0] instr);
        return {instr[7:0], instr[15:8], instr[23:16], instr[31:24]};
    endfunction
endpackage

// File: rtl/decode_logic.sv
// decode_logic: purely combinational decode of a five-byte instruction window
//   instr    in  40  fetched bytes, first byte in [39:32]
//   imm      out 32  decoded immediate
//   src1_idx out 3   destination / first-source register
//   src2_idx out 3   second-source register
//   ctrl     out 7   {src2mux, op, read1, read2, we, jmp, halt}
//   length   out 8   instruction length in bytes
module decode_logic
    import decode_pkg::*;
(
    input  logic [39:0] instr,
    output logic [31:0] imm,
    output logic [2:0]  src1_idx,
    output logic [2:0]  src2_idx,
    output logic [6:0]  ctrl,
    output logic [7:0]  length
);
    logic [7:0] opcode;
    logic [7:0] modrm;
    assign opcode = instr[39:32];
    assign modrm  = instr[31:24];
    // mod bits are ignored: every ModRM is treated as register-direct
    always_comb begin
        imm      = '0;
        src1_idx = '0;
        src2_idx = '0;
        ctrl     = CTRL_NOP;
        length   = LEN_1;
        if (opcode[7:3] == OP_MOV_HI) begin
            imm      = imm32(instr);
            src1_idx = opcode[2:0];
            ctrl     = CTRL_MOV_IMM;
            length   = LEN_5;
        end else if (opcode == OP_ADD_EAX) begin
            imm    = imm32(instr);
            ctrl   = CTRL_ADD_IMM;
            length = LEN_5;
        end else if (opcode == OP_ADD_RM) begin
            src1_idx = modrm[2:0];
            src2_idx = modrm[5:3];
            ctrl     = CTRL_ADD_REG;
            length   = LEN_2;
        end else if (opcode == OP_ADD_IMM8) begin
            imm      = {{24{instr[23]}}, instr[23:16]};
            src1_idx = modrm[2:0];
            ctrl     = CTRL_ADD_IMM;
            length   = LEN_3;
        end else if (opcode == OP_JMP) begin
            imm    = imm32(instr);
            ctrl   = CTRL_JMPREL;
            length = LEN_5;
        end else if (opcode == OP_HLT) begin
            ctrl = CTRL_HALTED;
        end
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: combinational instruction decode plus the decode/execute pipeline register
//   clk, rst        clock, synchronous active-high reset (beats stall)
//   pc, instr       fetched address and five instruction bytes
//   in_valid, stall input qualifier, hold request for the pipeline register
//   imm, src1_idx, src2_idx, ctrl, length   combinational decode of instr
//   d_*             registered copies plus d_pc, d_next_pc, d_valid
module decode_stage
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [39:0] instr,
    input  logic        in_valid,
    input  logic        stall,
    output logic [31:0] imm,
    output logic [2:0]  src1_idx,
    output logic [2:0]  src2_idx,
    output logic [6:0]  ctrl,
    output logic [7:0]  length,
    output logic        d_valid,
    output logic [31:0] d_pc,
    output logic [31:0] d_next_pc,
    output logic [31:0] d_imm,
    output logic [2:0]  d_src1_idx,
    output logic [2:0]  d_src2_idx,
    output logic [6:0]  d_ctrl,
    output logic [7:0]  d_length
);
    decode_logic u_decode (
        .instr    (instr),
        .imm      (imm),
        .src1_idx (src1_idx),
        .src2_idx (src2_idx),
        .ctrl     (ctrl),
        .length   (length)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            d_valid    <= 1'b0;
            d_pc       <= '0;
            d_next_pc  <= '0;
            d_imm      <= '0;
            d_src1_idx <= '0;
            d_src2_idx <= '0;
            d_ctrl     <= '0;
            d_length   <= '0;
        end else if (!stall) begin
            d_valid    <= in_valid;
            d_pc       <= pc;
            d_next_pc  <= pc + {24'd0, length};
            d_imm      <= imm;
            d_src1_idx <= src1_idx;
            d_src2_idx <= src2_idx;
            d_ctrl     <= ctrl;
            d_length   <= length;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard-driven self-checking bench for decode_stage
module tb_decode_stage;
    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [6:0]  ctrl;
        logic [7:0]  len;
    } cexp_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] npc;
        cexp_t       c;
    } pexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic [39:0] instr = '0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] imm;
    logic [2:0]  src1_idx, src2_idx;
    logic [6:0]  ctrl;
    logic [7:0]  length;
    logic        d_valid;
    logic [31:0] d_pc, d_next_pc, d_imm;
    logic [2:0]  d_src1_idx, d_src2_idx;
    logic [6:0]  d_ctrl;
    logic [7:0]  d_length;

    int checks = 0;
    int errors = 0;
    cexp_t cq[$];
    pexp_t pq[$];
    cexp_t obs_c;
    pexp_t obs_p;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .in_valid(in_valid), .stall(stall),
        .imm(imm), .src1_idx(src1_idx), .src2_idx(src2_idx), .ctrl(ctrl), .length(length),
        .d_valid(d_valid), .d_pc(d_pc), .d_next_pc(d_next_pc), .d_imm(d_imm),
        .d_src1_idx(d_src1_idx), .d_src2_idx(d_src2_idx), .d_ctrl(d_ctrl), .d_length(d_length)
    );

    assign obs_c = {imm, src1_idx, src2_idx, ctrl, length};
    assign obs_p = {d_valid, d_pc, d_next_pc, d_imm, d_src1_idx, d_src2_idx, d_ctrl, d_length};

    function automatic cexp_t model(input logic [39:0] in);
        logic [7:0]  op = in[39:32];
        logic [31:0] i32 = {in[7:0], in[15:8], in[23:16], in[31:24]};
        cexp_t e = {32'd0, 3'd0, 3'd0, 7'b0000000, 8'd1};
        if (op >= 8'hB8 && op <= 8'hBF) e = {i32, op[2:0], 3'd0, 7'b1000100, 8'd5};
        else if (op == 8'h05) e = {i32, 3'd0, 3'd0, 7'b1110100, 8'd5};
        else if (op == 8'h01) e = {32'd0, in[26:24], in[29:27], 7'b0111100, 8'd2};
        else if (op == 8'h83) e = {{{24{in[23]}}, in[23:16]}, in[26:24], 3'd0, 7'b1110100, 8'd3};
        else if (op == 8'hE9) e = {i32, 3'd0, 3'd0, 7'b0000010, 8'd5};
        else if (op == 8'hF4) e = {32'd0, 3'd0, 3'd0, 7'b0000001, 8'd1};
        return e;
    endfunction

    function automatic pexp_t pmodel(input logic v, input logic [31:0] p, input logic [39:0] in);
        cexp_t c = model(in);
        return {v, p, p + {24'd0, c.len}, c};
    endfunction

    function automatic logic [39:0] rand_instr();
        logic [39:0] r = {$urandom, 8'($urandom)};
        case ($urandom_range(0, 6))
            0: r[39:32] = 8'hB8 + 8'($urandom_range(0, 7));
            1: r[39:32] = 8'h05;
            2: r[39:32] = 8'h01;
            3: r[39:32] = 8'h83;
            4: r[39:32] = 8'hE9;
            5: r[39:32] = 8'hF4;
            default: ;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        cexp_t e;
        rst = 1'b1;
        instr = 40'hB8EFBEADDE;
        pq.push_back('0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_p !== pq.pop_front()) begin
            errors++;
            $display("FAIL reset_regs got=%h want=0", obs_p);
        end
        e = {32'hDEADBEEF, 3'd0, 3'd0, 7'b1000100, 8'd5};
        checks++;
        if (obs_c !== e) begin
            errors++;
            $display("FAIL comb_during_rst got=%h want=%h", obs_c, e);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [39:0] vi[11] = '{40'hB8EFBEADDE, 40'hB978563412, 40'hBF00000000, 40'h0505000000,
                                40'h0101000000, 40'h01D9000000, 40'h8300FF0000, 40'h83C27F0000,
                                40'hE9AA000000, 40'hF400000000, 40'h9011223344};
        cexp_t ve[11] = '{{32'hDEADBEEF, 3'd0, 3'd0, 7'b1000100, 8'd5},
                          {32'h12345678, 3'd1, 3'd0, 7'b1000100, 8'd5},
                          {32'h00000000, 3'd7, 3'd0, 7'b1000100, 8'd5},
                          {32'h00000005, 3'd0, 3'd0, 7'b1110100, 8'd5},
                          {32'h00000000, 3'd1, 3'd0, 7'b0111100, 8'd2},
                          {32'h00000000, 3'd1, 3'd3, 7'b0111100, 8'd2},
                          {32'hFFFFFFFF, 3'd0, 3'd0, 7'b1110100, 8'd3},
                          {32'h0000007F, 3'd2, 3'd0, 7'b1110100, 8'd3},
                          {32'h000000AA, 3'd0, 3'd0, 7'b0000010, 8'd5},
                          {32'h00000000, 3'd0, 3'd0, 7'b0000001, 8'd1},
                          {32'h00000000, 3'd0, 3'd0, 7'b0000000, 8'd1}};
        cexp_t e;
        for (int i = 0; i < 11; i++) begin
            instr = vi[i];
            cq.push_back(ve[i]);
            #1;
            e = cq.pop_front();
            checks++;
            if (obs_c !== e) begin
                errors++;
                $display("FAIL directed[%0d] instr=%h got=%h want=%h", i, vi[i], obs_c, e);
            end
        end
    endtask

    task automatic test_random_comb();
        cexp_t e;
        for (int i = 0; i < 60; i++) begin
            instr = rand_instr();
            cq.push_back(model(instr));
            #1;
            e = cq.pop_front();
            checks++;
            if (obs_c !== e) begin
                errors++;
                $display("FAIL random_comb instr=%h got=%h want=%h", instr, obs_c, e);
            end
        end
    endtask

    task automatic test_pipeline();
        pexp_t e;
        @(negedge clk);
        pc = 32'h1000; instr = 40'hB8EFBEADDE; in_valid = 1'b1; stall = 1'b0; rst = 1'b0;
        pq.push_back({1'b1, 32'h1000, 32'h1005, 32'hDEADBEEF, 3'd0, 3'd0, 7'b1000100, 8'd5});
        @(posedge clk); #1;
        e = pq.pop_front();
        checks++;
        if (obs_p !== e) begin
            errors++;
            $display("FAIL capture got=%h want=%h", obs_p, e);
        end
        @(negedge clk);
        stall = 1'b1; pc = 32'h2000; instr = 40'hF400000000; in_valid = 1'b0;
        pq.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        e = pq.pop_front();
        checks++;
        if (obs_p !== e) begin
            errors++;
            $display("FAIL stall_hold got=%h want=%h", obs_p, e);
        end
        @(negedge clk);
        rst = 1'b1;
        pq.push_back('0);
        @(posedge clk); #1;
        e = pq.pop_front();
        checks++;
        if (obs_p !== e) begin
            errors++;
            $display("FAIL rst_over_stall got=%h want=0", obs_p);
        end
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; pc = 32'hFFFFFFFE; instr = 40'hE9AA000000; in_valid = 1'b0;
        pq.push_back({1'b0, 32'hFFFFFFFE, 32'h00000003, 32'h000000AA, 3'd0, 3'd0, 7'b0000010, 8'd5});
        @(posedge clk); #1;
        e = pq.pop_front();
        checks++;
        if (obs_p !== e) begin
            errors++;
            $display("FAIL pc_wrap_invalid got=%h want=%h", obs_p, e);
        end
    endtask

    task automatic test_back_to_back();
        pexp_t held, e;
        @(negedge clk);
        rst = 1'b1; stall = 1'b0;
        held = '0;
        pq.push_back(held);
        @(posedge clk); #1;
        e = pq.pop_front();
        checks++;
        if (obs_p !== e) begin
            errors++;
            $display("FAIL b2b_reset got=%h want=%h", obs_p, e);
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 15) == 0);
            stall = ($urandom_range(0, 3) == 0);
            in_valid = 1'($urandom);
            pc = $urandom;
            instr = rand_instr();
            if (rst) held = '0;
            else if (!stall) held = pmodel(in_valid, pc, instr);
            pq.push_back(held);
            @(posedge clk); #1;
            e = pq.pop_front();
            checks++;
            if (obs_p !== e) begin
                errors++;
                $display("FAIL b2b[%0d] rst=%0b stall=%0b got=%h want=%h", i, rst, stall, obs_p, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_random_comb();
        test_pipeline();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
